// File: rtl/berger_zero_scrubber.sv
`default_nettype none
// ============================================================================
// Module      : berger_zero_scrubber
// Description : Background scrubber for a Berger zero-count protected memory.
//               Sweeps every codeword through a read port and checks that the
//               check field equals the number of zero bits in the data field.
//               Yields to host traffic through host_busy.
//               Optional macro BERGER_SCRUB_LOG_EN adds a FIFO of failing
//               addresses together with its log_valid/log_addr/log_pop ports.
// Revision    : 1.0 - initial release
// ============================================================================
module berger_zero_scrubber #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int CHK_W     = 4,
    parameter int RD_LAT    = 1
`ifdef BERGER_SCRUB_LOG_EN
    ,
    parameter int LOG_DEPTH = 4
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      continuous,
    input  logic                      clear,
    input  logic                      host_busy,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W+CHK_W-1:0]   mem_rdata,
    output logic                      busy,
    output logic                      done,
    output logic                      err_flag,
    output logic [ADDR_W:0]           err_count,
    output logic [ADDR_W-1:0]         first_err_addr
`ifdef BERGER_SCRUB_LOG_EN
    ,
    output logic                      log_valid,
    output logic [ADDR_W-1:0]         log_addr,
    input  logic                      log_pop
`endif
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ISSUE = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_CHECK = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam int c_LAT_W = $clog2(RD_LAT + 1);
    localparam logic [CHK_W-1:0] c_CHK_ONE = CHK_W'(1);

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic [ADDR_W-1:0]       r_addr;
    logic [c_LAT_W-1:0]      r_lat;
    logic [DATA_W+CHK_W-1:0] r_word;
    logic [DATA_W-1:0]       w_data;
    logic [CHK_W-1:0]        w_chk;
    logic [CHK_W-1:0]        w_zeros;
    logic                    w_lat_hit;
    logic                    w_check_err;
    logic                    w_start_acc;

    assign w_data      = r_word[DATA_W+CHK_W-1:CHK_W];
    assign w_chk       = r_word[CHK_W-1:0];
    assign w_lat_hit   = (r_lat == c_LAT_W'(RD_LAT));
    // A check value above DATA_W can never equal the zero count, so it is bad.
    assign w_check_err = (r_state == c_CHECK) && (w_chk != w_zeros);
    assign w_start_acc = (r_state == c_IDLE) && start;

    assign busy      = (r_state != c_IDLE);
    assign done      = (r_state == c_DONE);
    assign mem_rd_en = (r_state == c_ISSUE) && !host_busy;
    assign mem_addr  = r_addr;

    // Count zero bits of the captured data field.
    always_comb begin
        w_zeros = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (!w_data[i]) begin
                w_zeros = w_zeros + c_CHK_ONE;
            end
        end
    end

    // Sweep sequencing: issue, wait out the read latency, check, advance.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start || continuous) w_state_nxt = c_ISSUE;
            c_ISSUE: if (!host_busy)          w_state_nxt = c_WAIT;
            c_WAIT:  if (w_lat_hit)           w_state_nxt = c_CHECK;
            c_CHECK: w_state_nxt = (r_addr == '1) ? c_DONE : c_ISSUE;
            c_DONE:  w_state_nxt = continuous ? c_ISSUE : c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State, address counter, latency counter and captured codeword.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_addr  <= '0;
            r_lat   <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_ISSUE: r_lat <= c_LAT_W'(1);
                c_WAIT: begin
                    r_lat <= r_lat + c_LAT_W'(1);
                    if (w_lat_hit) begin
                        r_word <= mem_rdata;
                    end
                end
                c_CHECK: begin
                    if (r_addr != '1) begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                c_DONE:  r_addr <= '0;
                default: ;
            endcase
        end
    end

    // Error bookkeeping; clear outranks a same-cycle error update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_flag       <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (clear) begin
            err_flag       <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (w_start_acc) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (w_check_err) begin
            err_flag <= 1'b1;
            if (err_count != '1) begin
                err_count <= err_count + (ADDR_W+1)'(1);
            end
            if (err_count == '0) begin
                first_err_addr <= r_addr;
            end
        end
    end

`ifdef BERGER_SCRUB_LOG_EN
    localparam int c_PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(LOG_DEPTH + 1);

    logic [ADDR_W-1:0]  r_log_mem [LOG_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_log_cnt;
    logic               w_log_full;
    logic               w_log_empty;
    logic               w_log_push;
    logic               w_log_pop;

    function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(LOG_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign w_log_full  = (r_log_cnt == c_CNT_W'(LOG_DEPTH));
    assign w_log_empty = (r_log_cnt == '0);
    assign w_log_pop   = log_pop && !w_log_empty && !clear;
    // A full log still accepts a push when a pop frees a slot the same cycle.
    assign w_log_push  = w_check_err && !clear && (!w_log_full || w_log_pop);
    assign log_valid   = !w_log_empty;
    assign log_addr    = r_log_mem[r_rd_ptr];

    // Log pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_log_cnt <= '0;
        end else if (clear) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_log_cnt <= '0;
        end else begin
            if (w_log_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_log_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            if (w_log_push && !w_log_pop)      r_log_cnt <= r_log_cnt + c_CNT_W'(1);
            else if (!w_log_push && w_log_pop) r_log_cnt <= r_log_cnt - c_CNT_W'(1);
        end
    end

    // Log storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (w_log_push) begin
            r_log_mem[r_wr_ptr] <= r_addr;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_berger_zero_scrubber.sv
`default_nettype none
// ============================================================================
// Module      : tb_berger_zero_scrubber
// Description : Directed self-checking bench for berger_zero_scrubber with a
//               one-cycle-latency memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_berger_zero_scrubber;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int CHK_W  = 4;
    localparam int RD_LAT = 1;
    localparam int WORDS  = 16;
    localparam int SWEEP  = WORDS * (2 + RD_LAT) + 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    start = 1'b0;
    logic                    continuous = 1'b0;
    logic                    clear = 1'b0;
    logic                    host_busy = 1'b0;
    logic                    mem_rd_en;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W+CHK_W-1:0] mem_rdata = '0;
    logic                    busy;
    logic                    done;
    logic                    err_flag;
    logic [ADDR_W:0]         err_count;
    logic [ADDR_W-1:0]       first_err_addr;
`ifdef BERGER_SCRUB_LOG_EN
    logic                    log_valid;
    logic [ADDR_W-1:0]       log_addr;
    logic                    log_pop = 1'b0;
`endif

    logic [DATA_W+CHK_W-1:0] mem [WORDS];
    int checks = 0;
    int passes = 0;

    berger_zero_scrubber #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHK_W(CHK_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .clear(clear), .host_busy(host_busy), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .err_flag(err_flag), .err_count(err_count),
        .first_err_addr(first_err_addr)
`ifdef BERGER_SCRUB_LOG_EN
        , .log_valid(log_valid), .log_addr(log_addr), .log_pop(log_pop)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic fill_valid();
        for (int i = 0; i < WORDS; i++) mem[i] = (i % 2 == 0) ? 12'h008 : 12'hFF0;
        mem[3] = 12'hA54;   // 1010_0101 has four zeros
    endtask

    task automatic fill_two_bad();
        fill_valid();
        mem[5] = 12'h0F3;   // four zeros, check says three
        mem[9] = 12'h009;   // check nine exceeds data width
    endtask

    // Cycle count from the start-sampling edge to the negedge showing done.
    task automatic run_to_done(input int limit, output int cyc);
        cyc = 0;
        while (cyc < limit) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done === 1'b1) return;
        end
    endtask

    task automatic test_reset();
        logic [16:0] outs;
        repeat (2) @(negedge clk);
        outs = {busy, done, err_flag, err_count, first_err_addr, mem_rd_en, mem_addr};
        checks++;
        if (outs !== 17'd0) $display("FAIL reset_outputs: got %h want 0", outs);
        else passes++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_sweep();
        int cyc = 0;
        bit seen = 1'b0;
        fill_valid();
        start = 1'b1;
        while (cyc < 200 && !seen) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == 10) start = 1'b1;   // must be ignored while busy
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (cyc !== SWEEP) $display("FAIL clean_length: got %0d want %0d", cyc, SWEEP);
        else passes++;
        checks++;
        if (err_flag !== 1'b0 || err_count !== 5'd0)
            $display("FAIL clean_errors: got flag %b count %0d want 0 0", err_flag, err_count);
        else passes++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL clean_idle_after: got busy %b done %b want 0 0", busy, done);
        else passes++;
    endtask

    task automatic test_errors();
        int cyc;
        fill_two_bad();
        @(negedge clk);
        start = 1'b1;
        run_to_done(200, cyc);
        checks++;
        if (cyc !== SWEEP) $display("FAIL err_length: got %0d want %0d", cyc, SWEEP);
        else passes++;
        checks++;
        if (err_count !== 5'd2) $display("FAIL err_count: got %0d want 2", err_count);
        else passes++;
        checks++;
        if (first_err_addr !== 4'd5) $display("FAIL err_first: got %0d want 5", first_err_addr);
        else passes++;
        checks++;
        if (err_flag !== 1'b1) $display("FAIL err_flag: got %b want 1", err_flag);
        else passes++;
    endtask

    task automatic test_host_busy();
        int cyc = 0;
        int hold_bad = 0;
        bit seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        while (cyc < 300 && !seen) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc >= 10 && cyc <= 20 && (mem_rd_en !== 1'b0 || mem_addr !== 4'd3))
                hold_bad++;
            if (cyc == 9)  host_busy = 1'b1;   // during CHECK of address 2
            if (cyc == 20) host_busy = 1'b0;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (hold_bad !== 0) $display("FAIL hb_hold: got %0d bad cycles want 0", hold_bad);
        else passes++;
        checks++;
        if (cyc !== SWEEP + 10) $display("FAIL hb_length: got %0d want %0d", cyc, SWEEP + 10);
        else passes++;
        checks++;
        if (err_count !== 5'd2 || first_err_addr !== 4'd5)
            $display("FAIL hb_results: got count %0d first %0d want 2 5", err_count, first_err_addr);
        else passes++;
    endtask

    task automatic test_clear_collision();
        int cyc = 0;
        bit seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        while (cyc < 200 && !seen) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == 19) begin
                clear = 1'b0;
                checks++;
                if (err_count !== 5'd0 || err_flag !== 1'b0)
                    $display("FAIL clr_collide: got count %0d flag %b want 0 0", err_count, err_flag);
                else passes++;
            end
            if (cyc == 18) clear = 1'b1;   // CHECK of bad address 5
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (err_count !== 5'd1 || first_err_addr !== 4'd9 || err_flag !== 1'b1)
            $display("FAIL clr_after: got count %0d first %0d flag %b want 1 9 1",
                     err_count, first_err_addr, err_flag);
        else passes++;
    endtask

    task automatic test_continuous();
        int cyc;
        fill_valid();
        mem[5] = 12'h0F3;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        continuous = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            run_to_done(200, cyc);
            checks++;
            if (cyc !== SWEEP || err_count !== 5'(s))
                $display("FAIL cont_sweep%0d: got len %0d count %0d want %0d %0d",
                         s, cyc, err_count, SWEEP, s);
            else passes++;
        end
        repeat (20) @(negedge clk);
        continuous = 1'b0;
        run_to_done(200, cyc);
        checks++;
        if (cyc !== SWEEP - 20 || err_count !== 5'd4)
            $display("FAIL cont_drop: got len %0d count %0d want %0d 4", cyc, err_count, SWEEP - 20);
        else passes++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL cont_idle: got busy %b want 0", busy);
        else passes++;
    endtask

    task automatic test_reset_mid_sweep();
        int cyc = 0;
        int done_cnt = 0;
        logic [16:0] outs;
        fill_two_bad();
        @(negedge clk);
        start = 1'b1;
        while (cyc < 22) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        checks++;
        if (mem_addr !== 4'd7 || mem_rd_en !== 1'b1)
            $display("FAIL rst_pre: got addr %0d rd %b want 7 1", mem_addr, mem_rd_en);
        else passes++;
        rst = 1'b0;
        #1;
        outs = {busy, done, err_flag, err_count, first_err_addr, mem_rd_en, mem_addr};
        checks++;
        if (outs !== 17'd0) $display("FAIL rst_async: got %h want 0", outs);
        else passes++;
        @(negedge clk);
        rst = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) $display("FAIL rst_no_done: got %0d active cycles want 0", done_cnt);
        else passes++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (mem_addr !== 4'd0 || mem_rd_en !== 1'b1)
            $display("FAIL rst_restart: got addr %0d rd %b want 0 1", mem_addr, mem_rd_en);
        else passes++;
        run_to_done(200, cyc);
        checks++;
        if (cyc !== SWEEP - 1 || err_count !== 5'd2)
            $display("FAIL rst_resweep: got len %0d count %0d want %0d 2", cyc, err_count, SWEEP - 1);
        else passes++;
    endtask

    task automatic test_saturation();
        int cyc;
        for (int i = 0; i < WORDS; i++) mem[i] = 12'h000;
        @(negedge clk);
        start = 1'b1;
        continuous = 1'b1;
        run_to_done(200, cyc);
        checks++;
        if (err_count !== 5'd16 || first_err_addr !== 4'd0)
            $display("FAIL sat_first: got count %0d first %0d want 16 0", err_count, first_err_addr);
        else passes++;
        @(negedge clk);
        continuous = 1'b0;
        run_to_done(200, cyc);
        checks++;
        if (err_count !== 5'd31) $display("FAIL sat_cap: got %0d want 31", err_count);
        else passes++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL sat_idle: got busy %b want 0", busy);
        else passes++;
    endtask

`ifdef BERGER_SCRUB_LOG_EN
    task automatic test_log();
        int cyc;
        logic [ADDR_W-1:0] exp_addr [4];
        exp_addr[0] = 4'd1; exp_addr[1] = 4'd2; exp_addr[2] = 4'd3; exp_addr[3] = 4'd4;
        fill_valid();
        mem[1] = 12'h0E4; mem[2] = 12'h0E4; mem[3] = 12'h0E4;
        mem[4] = 12'h0E4; mem[6] = 12'h0E4; mem[8] = 12'h0E4;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if (log_valid !== 1'b0) $display("FAIL log_cleared: got %b want 0", log_valid);
        else passes++;
        start = 1'b1;
        run_to_done(200, cyc);
        checks++;
        if (err_count !== 5'd6) $display("FAIL log_count: got %0d want 6", err_count);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_valid !== 1'b1 || log_addr !== exp_addr[i])
                $display("FAIL log_pop%0d: got valid %b addr %0d want 1 %0d",
                         i, log_valid, log_addr, exp_addr[i]);
            else passes++;
            log_pop = 1'b1;
            @(negedge clk);
        end
        log_pop = 1'b0;
        checks++;
        if (log_valid !== 1'b0) $display("FAIL log_empty: got %b want 0", log_valid);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_clean_sweep();
        test_errors();
        test_host_busy();
        test_clear_collision();
        test_continuous();
        test_reset_mid_sweep();
        test_saturation();
`ifdef BERGER_SCRUB_LOG_EN
        test_log();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
